// File: rtl/sub_module_sched.sv
// sub_module_sched
// ----------------
// Shares one datapath instance among NUM_REQ requesters. A job is chosen by
// round-robin arbitration and then runs through five steps: its 16-bit config
// is captured, an ROWS x 16-byte tile is loaded one 128-bit row per beat,
// start is pulsed, and the controller waits for done or a timeout. The 8-bit
// result is then returned to the requester that owns the job.
//
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   req_valid    : per-requester job request (sampled only while idle)
//   req_cfg      : per-requester 16-bit config, slice i = requester i
//   grant        : one-hot owner of the current job, zero when idle
//   ld_valid     : row beat valid on the shared load bus
//   ld_data      : tile row, byte k maps to column k
//   ld_ready     : controller accepts a row this cycle
//   dp_cfg       : config to the datapath
//   dp_tile      : tile to the datapath, row r at bits [128r+127:128r]
//   dp_start     : one-cycle start pulse to the datapath
//   dp_done      : datapath completion (honoured only while waiting)
//   dp_result    : datapath result byte
//   rsp_valid    : response available
//   rsp_ready    : response accepted
//   rsp_id       : requester index of the response
//   rsp_data     : result byte (0 on timeout)
//   rsp_err      : 1 = datapath timed out
//   busy         : controller is not idle
// All outputs are registered.

module sub_module_sched #(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 8,
    parameter int TO_W    = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_cfg,
    output logic [NUM_REQ-1:0]      grant,
    input  logic                    ld_valid,
    input  logic [127:0]            ld_data,
    output logic                    ld_ready,
    output logic [15:0]             dp_cfg,
    output logic [ROWS*128-1:0]     dp_tile,
    output logic                    dp_start,
    input  logic                    dp_done,
    input  logic [7:0]              dp_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [TO_W-1:0]    TO_LIMIT   = {TO_W{1'b1}};
    localparam logic [TO_W-1:0]    TO_ONE     = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] ONEHOT0    = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   ROW_ONE    = {{(ROW_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cand;
    logic               win_found;
    logic [ROW_W-1:0]   row_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [TO_W-1:0]    to_inc;
    logic               take_grant;
    logic               beat;
    logic               last_beat;
    logic               wait_done;
    logic               wait_to;
    logic               rsp_hs;

    // Round-robin search: first asserted request after the last winner, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end else begin
                win_found = win_found;
            end
        end
    end

    // Next-state logic and the per-cycle event strobes that drive the registers.
    always_comb begin
        state_nxt  = state;
        take_grant = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        wait_done  = 1'b0;
        wait_to    = 1'b0;
        rsp_hs     = 1'b0;
        // The limit is compared against the count including this cycle, so a
        // silent datapath gets exactly TO_LIMIT cycles in WAIT.
        to_inc     = to_cnt + TO_ONE;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    take_grant = 1'b1;
                    state_nxt  = S_LOAD;
                end else begin
                    state_nxt  = S_IDLE;
                end
            end
            S_LOAD: begin
                beat = ld_valid && ld_ready;
                if (beat && (row_cnt == ROW_LAST)) begin
                    last_beat = 1'b1;
                    state_nxt = S_START;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done has priority over a coinciding timeout
                if (dp_done) begin
                    wait_done = 1'b1;
                    state_nxt = S_RESP;
                end else if (to_inc == TO_LIMIT) begin
                    wait_to   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration results and the job-frozen config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            dp_cfg     <= 16'h0000;
            busy       <= 1'b0;
        end else begin
            if (take_grant) begin
                grant      <= ONEHOT0 << win_idx;
                last_grant <= win_idx;
                dp_cfg     <= req_cfg[32'(win_idx) * 32'd16 +: 16];
            end else if (rsp_hs) begin
                grant <= '0;
            end
            busy <= (state_nxt != S_IDLE);
        end
    end

    // Tile load: row counter, ready flag and row storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ready <= 1'b0;
            row_cnt  <= '0;
            dp_tile  <= '0;
        end else begin
            if (take_grant) begin
                ld_ready <= 1'b1;
            end else if (last_beat) begin
                ld_ready <= 1'b0;
            end
            if (beat) begin
                row_cnt <= last_beat ? '0 : (row_cnt + ROW_ONE);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (beat && (row_cnt == ROW_W'(r))) begin
                    dp_tile[r*128 +: 128] <= ld_data;
                end
            end
        end
    end

    // Start pulse and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_start <= 1'b0;
            to_cnt   <= '0;
        end else begin
            dp_start <= last_beat;
            if (state == S_START) begin
                to_cnt <= '0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_inc;
            end
        end
    end

    // Response capture; fields are held until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            if (wait_done) begin
                rsp_valid <= 1'b1;
                rsp_id    <= last_grant;
                rsp_data  <= dp_result;
                rsp_err   <= 1'b0;
            end else if (wait_to) begin
                rsp_valid <= 1'b1;
                rsp_id    <= last_grant;
                rsp_data  <= 8'h00;
                rsp_err   <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
